mcu_tick_irq_timer: RTL and testbench

//  N_CH-channel programmable periodic tick/interrupt generator for the yrv_mcu board tops.

---
 rtl/mcu_tick_irq_timer_pkg.sv | 10 +
 rtl/mcu_tick_irq_timer_if.sv | 28 ++
 rtl/mcu_tick_irq_timer_channel.sv | 67 ++++++
 rtl/mcu_tick_irq_timer.sv | 56 +++++
 tb/tb_mcu_tick_irq_timer.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/mcu_tick_irq_timer_pkg.sv
// Shared helpers for the tick/interrupt timer: rate-to-terminal-count conversion.
package mcu_tick_irq_pkg;

    function automatic int unsigned hz_to_term(input int unsigned clk_hz, input int unsigned hz);
        return clk_hz / hz - 1;
    endfunction

    localparam int unsigned DEFAULT_TERM = hz_to_term(50_000_000, 125);

endpackage

// File: rtl/mcu_tick_irq_timer_if.sv
// Configuration and interrupt bundle between the MCU top and the tick timer.
interface mcu_tick_irq_timer_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 24
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_term;
    logic [N_CH-1:0]  ch_en;
    logic [N_CH-1:0]  irq_mask;
    logic [N_CH-1:0]  ack;
    logic [N_CH-1:0]  tick;
    logic [N_CH-1:0]  irq_pending;
    logic [N_CH-1:0]  irq_overrun;
    logic             ei_req;

    modport master (
        output cfg_we, cfg_ch, cfg_term, ch_en, irq_mask, ack,
        input  tick, irq_pending, irq_overrun, ei_req
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_term, ch_en, irq_mask, ack,
        output tick, irq_pending, irq_overrun, ei_req
    );
endinterface

// File: rtl/mcu_tick_irq_timer_channel.sv
// One timer channel: period counter, programmable terminal count, tick and sticky pending/overrun.
module mcu_tick_irq_channel
    import mcu_tick_irq_pkg::*;
#(
    parameter int               CNT_W    = 24,
    parameter logic [CNT_W-1:0] TERM_RST = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_wr,
    input  logic [CNT_W-1:0] cfg_term,
    input  logic             en,
    input  logic             mask,
    input  logic             ack,
    output logic             tick,
    output logic             pending,
    output logic             overrun
);
    logic [CNT_W-1:0] cnt_q, cnt_d, term_q, term_d;
    logic             tick_q, tick_d, pend_q, pend_d, ovr_q, ovr_d;
    logic             hit;

    always_comb begin
        hit    = en && (cnt_q == term_q);
        term_d = term_q;
        cnt_d  = (!en || hit) ? '0 : cnt_q + 1'b1;
        // A write restarts the period; a hit in the same cycle has already been taken above.
        if (cfg_wr) begin
            term_d = cfg_term;
            cnt_d  = '0;
        end
        tick_d = hit;
        pend_d = pend_q;
        ovr_d  = ovr_q;
        if (mask) begin
            pend_d = 1'b0;
            ovr_d  = 1'b0;
        end else if (hit && pend_q && !ack) begin
            ovr_d  = 1'b1;
        end else if (hit) begin
            pend_d = 1'b1;
        end else if (ack) begin
            pend_d = 1'b0;
            ovr_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            term_q <= TERM_RST;
            tick_q <= 1'b0;
            pend_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            term_q <= term_d;
            tick_q <= tick_d;
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
        end
    end

    assign tick    = tick_q;
    assign pending = pend_q;
    assign overrun = ovr_q;
endmodule

// File: rtl/mcu_tick_irq_timer.sv
// N_CH-channel periodic tick/interrupt generator; channel pendings are ORed into ei_req.
module mcu_tick_irq_timer
    import mcu_tick_irq_pkg::*;
#(
    parameter int CLK_FREQUENCY = 50_000_000,
    parameter int N_CH          = 4,
    parameter int CNT_W         = 24,
    parameter int DEFAULT_HZ    = 125
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mcu_tick_irq_timer_if.slave  bus
);
    localparam int unsigned      TERM_INT = hz_to_term(CLK_FREQUENCY, DEFAULT_HZ);
    localparam logic [CNT_W-1:0] TERM_RST = CNT_W'(TERM_INT);
    localparam int               CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;

    generate
        if ($clog2(64'(TERM_INT) + 64'd1) > CNT_W) begin : g_term_chk
            $error("CNT_W too narrow for default terminal count");
        end
    endgenerate

    logic [N_CH-1:0] cfg_wr, tick, pend, ovr;

    // Out-of-range channel numbers match no channel and are dropped.
    always_comb begin
        cfg_wr = '0;
        for (int i = 0; i < N_CH; i++) begin
            cfg_wr[i] = bus.cfg_we && (bus.cfg_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        mcu_tick_irq_channel #(
            .CNT_W    (CNT_W),
            .TERM_RST (TERM_RST)
        ) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .cfg_wr   (cfg_wr[g]),
            .cfg_term (bus.cfg_term),
            .en       (bus.ch_en[g]),
            .mask     (bus.irq_mask[g]),
            .ack      (bus.ack[g]),
            .tick     (tick[g]),
            .pending  (pend[g]),
            .overrun  (ovr[g])
        );
    end

    assign bus.tick        = tick;
    assign bus.irq_pending = pend;
    assign bus.irq_overrun = ovr;
    assign bus.ei_req      = |pend;
endmodule

// File: tb/tb_mcu_tick_irq_timer.sv
// Directed + randomized bench for mcu_tick_irq_timer against a period/elapsed-time reference model.
module tb_mcu_tick_irq_timer;
    localparam int N       = 3;
    localparam int W       = 24;
    localparam int CLKF    = 1000;
    localparam int HZ      = 125;
    localparam int DEF_PER = CLKF / HZ;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mcu_tick_irq_timer_if #(.N_CH(N), .CNT_W(W)) bus ();

    mcu_tick_irq_timer #(
        .CLK_FREQUENCY (CLKF),
        .N_CH          (N),
        .CNT_W         (W),
        .DEFAULT_HZ    (HZ)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: each channel has a period in clocks and the number of enabled clocks since restart.
    int unsigned    per[N];
    int unsigned    el[N];
    logic [N-1:0]   m_tick, m_pend, m_ovr;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_tick"}, bus.tick, m_tick);
        chk({tag, "_pend"}, bus.irq_pending, m_pend);
        chk({tag, "_ovr"},  bus.irq_overrun, m_ovr);
        chk({tag, "_ei"},   {{(N-1){1'b0}}, bus.ei_req}, {{(N-1){1'b0}}, |m_pend});
    endtask

    function automatic bit mhit(input int i);
        return bus.ch_en[i] && (el[i] % per[i] == per[i] - 1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            per[i] = DEF_PER;
            el[i]  = 0;
        end
        m_tick = '0;
        m_pend = '0;
        m_ovr  = '0;
    endtask

    task automatic step(input string tag);
        logic [N-1:0] h;
        for (int i = 0; i < N; i++) h[i] = mhit(i);
        for (int i = 0; i < N; i++) begin
            if (bus.cfg_we && int'(bus.cfg_ch) == i) begin
                per[i] = int'(bus.cfg_term) + 1;
                el[i]  = 0;
            end else if (!bus.ch_en[i]) el[i] = 0;
            else el[i] = el[i] + 1;
            if (bus.irq_mask[i]) begin
                m_pend[i] = 1'b0;
                m_ovr[i]  = 1'b0;
            end else if (h[i] && m_pend[i] && !bus.ack[i]) m_ovr[i] = 1'b1;
            else if (h[i]) m_pend[i] = 1'b1;
            else if (bus.ack[i]) begin
                m_pend[i] = 1'b0;
                m_ovr[i]  = 1'b0;
            end
        end
        m_tick = h;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic wait_hit(input int i, input string tag);
        int n = 0;
        while (!mhit(i) && n < 64) begin
            step(tag);
            n++;
        end
        checks++;
        if (!mhit(i)) begin
            errors++;
            $error("FAIL %s_timeout: observed no hit expected hit on ch%0d", tag, i);
        end
    endtask

    initial begin
        bus.cfg_we   = 1'b0;
        bus.cfg_ch   = '0;
        bus.cfg_term = '0;
        bus.ch_en    = '0;
        bus.irq_mask = '0;
        bus.ack      = '0;
        model_reset();
        #12;
        check_all("reset");
        reset_n = 1'b1;

        // Default period on channel 0
        bus.ch_en = 3'b001;
        repeat (20) step("t1");

        // Short period on channel 1, pending then ack
        bus.cfg_we = 1'b1; bus.cfg_ch = 2'd1; bus.cfg_term = 24'd3; bus.ch_en = 3'b011;
        step("t2_cfg");
        bus.cfg_we = 1'b0;
        wait_hit(1, "t2");
        step("t2_hit");
        chk("t2_pend1", {2'b0, bus.irq_pending[1]}, 3'b001);
        bus.ack = 3'b010; step("t2_ack"); bus.ack = '0;

        // Overrun without ack, then ack clears both
        repeat (9) step("t3");
        chk("t3_ovr1", {2'b0, bus.irq_overrun[1]}, 3'b001);
        bus.ack = 3'b010; step("t3_ack"); bus.ack = '0;

        // Ack coinciding with a hit while pending: set wins, no overrun
        wait_hit(1, "t4a");
        step("t4_set");
        wait_hit(1, "t4b");
        bus.ack = 3'b010; step("t4_ackhit"); bus.ack = '0;
        chk("t4_pend1", {2'b0, bus.irq_pending[1]}, 3'b001);
        chk("t4_ovr1",  {2'b0, bus.irq_overrun[1]}, 3'b000);
        bus.ack = 3'b010; step("t4_clr"); bus.ack = '0;

        // Masked channel 2 still ticks; unmask sets pending on next hit
        bus.ch_en = 3'b001;
        bus.irq_mask = 3'b100;
        bus.cfg_we = 1'b1; bus.cfg_ch = 2'd2; bus.cfg_term = 24'd1; bus.ch_en = 3'b101;
        step("t5_cfg");
        bus.cfg_we = 1'b0;
        repeat (8) step("t5");
        bus.irq_mask = 3'b000;
        wait_hit(2, "t5u");
        step("t5_unmask");
        chk("t5_pend2", {2'b0, bus.irq_pending[2]}, 3'b001);

        // Rewrite term mid-count on channel 0; out-of-range channel write is dropped
        bus.cfg_we = 1'b1; bus.cfg_ch = 2'd0; bus.cfg_term = 24'd9;
        step("t6_cfg");
        bus.cfg_we = 1'b0;
        for (int n = 0; n < 20 && el[0] % per[0] != 5; n++) step("t6_run");
        bus.cfg_we = 1'b1; bus.cfg_term = 24'd2;
        step("t6_rew");
        bus.cfg_ch = 2'd3; bus.cfg_term = 24'd0;
        step("t6_bad");
        bus.cfg_we = 1'b0;
        repeat (8) step("t6");

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 15) == 0) bus.ch_en = N'($urandom);
            bus.irq_mask = N'($urandom & $urandom & $urandom & $urandom);
            bus.ack      = N'($urandom & $urandom);
            bus.cfg_we   = ($urandom_range(0, 19) == 0);
            bus.cfg_ch   = 2'($urandom_range(0, 3));
            bus.cfg_term = 24'($urandom_range(0, 6));
            step("rnd");
        end
        bus.cfg_we = 1'b0; bus.ack = '0; bus.irq_mask = '0;

        // Asynchronous reset mid-run restores defaults
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("areset");
        #2;
        reset_n = 1'b1;
        bus.ch_en = 3'b001;
        repeat (20) step("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
